// File: rtl/operand_fetch.sv
// Operand fetch: 8x16 register file plus a 4-state read sequencer feeding the ALU.
// Define OPERAND_FETCH_BYPASS_EN to forward same-edge writes into the A/B reads.
module operand_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic        write,
   input  logic [2:0]  writenum,
   input  logic [15:0] data_in,
   input  logic        start,
   input  logic [2:0]  rn,
   input  logic [2:0]  rm,
   input  logic [1:0]  shift,
   input  logic        asel,
   input  logic        bsel,
   input  logic [15:0] sximm5,
   output logic [15:0] Ain,
   output logic [15:0] Bin,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READA,
      S_READB,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_regs [8];
   logic [2:0]  r_rn;
   logic [2:0]  r_rm;
   logic [1:0]  r_shift;
   logic        r_asel;
   logic        r_bsel;
   logic [15:0] r_sximm5;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic        w_accept;
   logic [15:0] w_rd_a;
   logic [15:0] w_rd_b;
   logic [15:0] w_shifted;

   always_comb begin
      w_accept = 1'b0;
      w_next   = r_state;
      case (r_state)
         S_IDLE: begin
            w_accept = start;
            if (start) w_next = S_READA;
         end
         S_READA: w_next = S_READB;
         S_READB: w_next = S_DONE;
         S_DONE: begin
            w_accept = start;
            w_next   = start ? S_READA : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      end else if (write) begin
         r_regs[writenum] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rn     <= '0;
         r_rm     <= '0;
         r_shift  <= '0;
         r_asel   <= 1'b0;
         r_bsel   <= 1'b0;
         r_sximm5 <= '0;
      end else if (w_accept) begin
         r_rn     <= rn;
         r_rm     <= rm;
         r_shift  <= shift;
         r_asel   <= asel;
         r_bsel   <= bsel;
         r_sximm5 <= sximm5;
      end
   end

`ifdef OPERAND_FETCH_BYPASS_EN
   // A write landing on the read edge wins over the stored value.
   assign w_rd_a = (write && writenum == r_rn) ? data_in : r_regs[r_rn];
   assign w_rd_b = (write && writenum == r_rm) ? data_in : r_regs[r_rm];
`else
   assign w_rd_a = r_regs[r_rn];
   assign w_rd_b = r_regs[r_rm];
`endif

   always_comb begin
      w_shifted = w_rd_b;
      case (r_shift)
         2'b00: w_shifted = w_rd_b;
         2'b01: w_shifted = {w_rd_b[14:0], 1'b0};
         2'b10: w_shifted = {1'b0, w_rd_b[15:1]};
         2'b11: w_shifted = {w_rd_b[15], w_rd_b[15:1]};
         default: w_shifted = w_rd_b;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         if (r_state == S_READA) r_a <= w_rd_a;
         if (r_state == S_READB) r_b <= w_shifted;
      end
   end

   assign Ain  = r_asel ? 16'h0000 : r_a;
   assign Bin  = r_bsel ? r_sximm5 : r_b;
   assign busy = (r_state == S_READA) || (r_state == S_READB);
   assign done = (r_state == S_DONE);

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port write, input, 1, register file write enable.
REQ-004 SHALL have port writenum, input, 3, write target register R0-R7.
REQ-005 SHALL have port data_in, input, 16, write data.
REQ-006 SHALL have port start, input, 1, single-cycle operand fetch request.
REQ-007 SHALL have port rn, input, 3, register index for the A operand.
REQ-008 SHALL have port rm, input, 3, register index for the B operand.
REQ-009 SHALL have port shift, input, 2, shift code for the B operand.
REQ-010 SHALL have port asel, input, 1, Ain forced to zero when 1.
REQ-011 SHALL have port bsel, input, 1, Bin takes sximm5 when 1.
REQ-012 SHALL have port sximm5, input, 16, sign-extended immediate.
REQ-013 SHALL have port Ain, output, 16, ALU A operand.
REQ-014 SHALL have port Bin, output, 16, ALU B operand.
REQ-015 SHALL have port busy, output, 1, high in READA and READB.
REQ-016 SHALL have port done, output, 1, high for exactly the DONE cycle; Ain/Bin valid.

Function
REQ-017 SHALL hold 8x16 registers R0-R7; on clk edge with write=1, R[writenum] <= data_in, independent of FSM state.
REQ-018 SHALL implement FSM IDLE->READA->READB->DONE->IDLE, one state per clock.
REQ-019 SHALL accept start only in IDLE or DONE, capturing rn, rm, shift, asel, bsel, sximm5 into internal registers on that edge and going to READA; start in READA/READB ignored, no queuing.
REQ-020 SHALL on READA exit edge load A <= R[rn_q]; on READB exit edge load B <= shifted R[rm_q].
REQ-021 SHALL shift: 00 pass; 01 left 1, zero fill; 10 logical right 1; 11 arithmetic right 1 (bit15 replicated).
REQ-022 SHALL drive Ain = asel_q ? 16'h0000 : A and Bin = bsel_q ? sximm5_q : B, combinationally from registered values, in every state.
REQ-023 SHALL give latency start edge -> done high = 3 clock cycles; DONE with start=1 proceeds directly to READA (back-to-back, 3-cycle throughput).
REQ-024 SHALL hold A, B and captured fields stable outside their load edges.
REQ-025 SHALL make writes to R[rn_q]/R[rm_q] earlier than the READA/READB edge visible to that read.

Reset
REQ-026 SHALL on reset=1, immediately and irrespective of clk, clear R0-R7, A, B and all captured fields to 0 and force FSM to IDLE; busy=done=0, Ain=Bin=0.
REQ-027 SHALL abandon a fetch interrupted by reset; no done is produced for it.
REQ-028 SHALL ignore start and write while reset=1; first start accepted on the first edge after reset deasserts.

Configuration
REQ-029 SHALL, with macro OPERAND_FETCH_BYPASS_EN defined, forward data_in to the read when write=1 and writenum equals the index read on the same READA or READB edge.
REQ-030 SHALL, without OPERAND_FETCH_BYPASS_EN, return the pre-write register value in that case; the write still completes.

Verification
REQ-031 SHALL cover: write R2=16'h0005, R3=16'h0003; start rn=2 rm=3 shift=00 asel=0 bsel=0 -> done at cycle 3, Ain=0005, Bin=0003.
REQ-032 SHALL cover: R3=16'h8001, shift 01/10/11 -> Bin=0002/4000/C000 respectively.
REQ-033 SHALL cover: asel=1 bsel=1 sximm5=16'hFFF0 -> Ain=0000, Bin=FFF0 at done.
REQ-034 SHALL cover: write R2=16'h1234 on the READA edge of fetch rn=2 with old R2=0005 -> Ain=1234 with macro, 0005 without.
REQ-035 SHALL cover: start during READA ignored, then start asserted in DONE -> second done exactly 3 cycles after first.
REQ-036 SHALL cover: reset asserted mid-READB -> busy=done=0, Ain=Bin=0 immediately, all registers read 0 afterward.
